store_buffer_unit: RTL

- Parametrised successor to the single-cycle store datapath.
- Accepts store requests as base register value, store data and immediate offset, plus an access size (sb/sh/sw/sd).
- Computes the effective address, byte strobes and lane-aligned write data, then queues each store in a DEPTH-entry FIFO.
- Drains the FIFO to data memory over a valid/ready port, so the pipeline does not stall on a busy memory.

---
 rtl/store_buffer_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: store request datapath with a DEPTH-entry drain FIFO.
// Each request (base + offset, data, size) is turned into an XLEN/8-aligned
// address, byte strobes and lane-shifted write data, and then queued. The
// queue drains to data memory over a valid/ready port.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : illegal requests are accepted, dropped, and flagged on misalign
//   undefined : misaligned requests are force-aligned and pushed normally
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_ready = !full)
//   req_base/data/offset/size  store operands; size 0..3 = byte..double
//   mem_valid/mem_ready        drain handshake for the head entry
//   mem_addr/wdata/wstrb       head entry payload
//   count, empty, full         occupancy
//   misalign, misalign_addr    rejected-request pulse and its address
module store_buffer_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_base,
  input  logic [XLEN-1:0]          req_data,
  input  logic [XLEN-1:0]          req_offset,
  input  logic [1:0]               req_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     misalign,
  output logic [XLEN-1:0]          misalign_addr
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned LW = $clog2(SW);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] addr_q  [DEPTH];
  logic [XLEN-1:0] wdata_q [DEPTH];
  logic [SW-1:0]   wstrb_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  logic [XLEN-1:0] ea_c, low_c, ea_al_c, addr_c, dmask_c, wdata_c;
  logic [SW-1:0]   smask_c, wstrb_c;
  logic [LW-1:0]   lane_c;
  logic [1:0]      size_c;
  logic            accept_c, push_c, pop_c, trap_c;
  logic [PW-1:0]   wr_n_c, rd_n_c;
  logic [CW-1:0]   count_n_c;
  logic [XLEN-1:0] head_addr_c, head_wdata_c;
  logic [SW-1:0]   head_wstrb_c;

  // Request decode: effective address, alignment, strobes and lane data
  always_comb begin
    ea_c   = req_base + req_offset;
    size_c = req_size;
`ifndef MISALIGN_TRAP_EN
    // A double store on a 32-bit datapath degrades to a word store
    if (XLEN == 32 && req_size == 2'd3) size_c = 2'd2;
`endif
    case (size_c)
      2'd0:    begin low_c = XLEN'(0); smask_c = SW'(8'h01); dmask_c = XLEN'(8'hFF);        end
      2'd1:    begin low_c = XLEN'(1); smask_c = SW'(8'h03); dmask_c = XLEN'(16'hFFFF);     end
      2'd2:    begin low_c = XLEN'(3); smask_c = SW'(8'h0F); dmask_c = XLEN'(32'hFFFF_FFFF); end
      default: begin low_c = XLEN'(7); smask_c = SW'(8'hFF); dmask_c = {XLEN{1'b1}};        end
    endcase
    ea_al_c = ea_c & ~low_c;
    lane_c  = ea_al_c[LW-1:0];
    addr_c  = ea_al_c & ~XLEN'(SW - 1);
    wstrb_c = smask_c << lane_c;
    wdata_c = (req_data & dmask_c) << {lane_c, 3'b000};
  end

  // Handshake, push/pop and pointer arithmetic
  always_comb begin
    accept_c = req_valid && req_ready;
`ifdef MISALIGN_TRAP_EN
    trap_c   = accept_c && (((ea_c & low_c) != '0) || (XLEN == 32 && req_size == 2'd3));
    push_c   = accept_c && !trap_c;
`else
    trap_c   = 1'b0;
    push_c   = accept_c;
`endif
    pop_c     = mem_valid && mem_ready;
    wr_n_c    = push_c ? wr_ptr + PW'(1) : wr_ptr;
    rd_n_c    = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
    count_n_c = count + CW'(push_c) - CW'(pop_c);
    // New head: bypass the incoming entry when it lands in the head slot
    if (push_c && wr_ptr == rd_n_c) begin
      head_addr_c  = addr_c;
      head_wdata_c = wdata_c;
      head_wstrb_c = wstrb_c;
    end else begin
      head_addr_c  = addr_q[rd_n_c];
      head_wdata_c = wdata_q[rd_n_c];
      head_wstrb_c = wstrb_q[rd_n_c];
    end
  end

  // Entry storage; contents are only observed through valid pointers
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[wr_ptr]  <= addr_c;
      wdata_q[wr_ptr] <= wdata_c;
      wstrb_q[wr_ptr] <= wstrb_c;
    end
  end

  // Pointers, occupancy flags and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      req_ready     <= 1'b0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wr_ptr    <= wr_n_c;
      rd_ptr    <= rd_n_c;
      count     <= count_n_c;
      empty     <= (count_n_c == '0);
      full      <= (count_n_c == CW'(DEPTH));
      req_ready <= (count_n_c != CW'(DEPTH));
      mem_valid <= (count_n_c != '0);
      // Hold last payload when the buffer goes empty
      if (count_n_c != '0) begin
        mem_addr  <= head_addr_c;
        mem_wdata <= head_wdata_c;
        mem_wstrb <= head_wstrb_c;
      end
      misalign <= trap_c;
      if (trap_c) misalign_addr <= ea_c;
    end
  end

endmodule
